// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op encodings and condition-code layout for alu_pipe
package alu_pkg;

  // Condition-code register width and bit positions {ZF,SF,OF}
  localparam int CC_W  = 3;
  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  // Operation encodings carried on the op port
  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_XOR = 2'b11
  } op_e;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU producing result and {ZF,SF,OF}
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [CC_W-1:0]  flags
);

  logic [WIDTH-1:0] res;
  logic             ovf;

  // Operate on b (op) a; overflow is judged on sign bits of operands vs result
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        res = b + a;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res = b - a;
        ovf = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != b[WIDTH-1]);
      end
      OP_AND: res = a & b;
      OP_XOR: res = a ^ b;
      default: res = '0;
    endcase
    flags        = '0;
    flags[CC_ZF] = (res == '0);
    flags[CC_SF] = res[WIDTH-1];
    flags[CC_OF] = ovf;
    result       = res;
  end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline with condition-code register
module alu_pipe
  import alu_pkg::*;
#(
  parameter int              WIDTH    = 64,
  parameter logic [CC_W-1:0] CC_RESET = 3'b100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_cc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [CC_W-1:0]  flags,
  output logic [CC_W-1:0]  cc
);

  logic             s1_valid_q, s1_valid_d;
  op_e              s1_op_q, s1_op_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic             s1_set_cc_q, s1_set_cc_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_result_q, s2_result_d;
  logic [CC_W-1:0]  s2_flags_q, s2_flags_d;
  logic             s2_set_cc_q, s2_set_cc_d;

  logic [CC_W-1:0]  cc_q, cc_d;

  logic [WIDTH-1:0] alu_result;
  logic [CC_W-1:0]  alu_flags;
  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op     (s1_op_q),
    .a      (s1_a_q),
    .b      (s1_b_q),
    .result (alu_result),
    .flags  (alu_flags)
  );

  // Handshakes: S1 moves whenever S2 is empty or draining; flush and reset block intake
  always_comb begin
    s1_adv   = !s2_valid_q || out_ready;
    in_ready = !reset && !flush && (!s1_valid_q || s1_adv);
    in_fire  = in_valid && in_ready;
    out_fire = s2_valid_q && out_ready;
  end

  // Next-state for both stages and the architectural CC register
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_set_cc_d = s1_set_cc_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_flags_d  = s2_flags_q;
    s2_set_cc_d = s2_set_cc_q;
    cc_d        = cc_q;

    if (in_fire) begin
      s1_op_d     = op_e'(op);
      s1_a_d      = a;
      s1_b_d      = b;
      s1_set_cc_d = set_cc;
    end
    if (s1_adv && s1_valid_q) begin
      s2_result_d = alu_result;
      s2_flags_d  = alu_flags;
      s2_set_cc_d = s1_set_cc_q;
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else if (s1_adv) begin
      s1_valid_d = in_fire;
      s2_valid_d = s1_valid_q;
    end

    // A beat retiring in a flush cycle still completes and may update cc
    if (out_fire && s2_set_cc_q) begin
      cc_d = s2_flags_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_set_cc_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
      s2_set_cc_q <= 1'b0;
      cc_q        <= CC_RESET;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_set_cc_q <= s1_set_cc_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_flags_q  <= s2_flags_d;
      s2_set_cc_q <= s2_set_cc_d;
      cc_q        <= cc_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = s2_result_q;
  assign flags     = s2_flags_q;
  assign cc        = cc_q;

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, 64, operand/result width in bits; legal range 8..64.
REQ-002 Parameter: CC_RESET, 3'b100, reset value of the condition-code register {ZF,SF,OF}.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  request presented.
REQ-006 in_ready  output  1  block accepts the request this cycle.
REQ-007 op  input  2  00 ADD, 01 SUB, 10 AND, 11 XOR.
REQ-008 a  input  WIDTH  operand A, two's complement.
REQ-009 b  input  WIDTH  operand B, two's complement.
REQ-010 set_cc  input  1  this request updates the CC register when it retires.
REQ-011 flush  input  1  discard all in-flight requests.
REQ-012 out_valid  output  1  result presented.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 result  output  WIDTH  operation result.
REQ-015 flags  output  3  {ZF,SF,OF} of the presented result.
REQ-016 cc  output  3  architectural CC register {ZF,SF,OF}.

Function
REQ-017 ADD: result = b + a; SUB: result = b - a; AND: a & b; XOR: a ^ b; all modulo 2^WIDTH.
REQ-018 ZF = (result == 0); SF = result[WIDTH-1]; OF(ADD) = a,b same sign and result sign differs; OF(SUB) = a,b differ in sign and result sign differs from b; OF = 0 for AND/XOR.
REQ-019 Two registered stages: S1 holds op/a/b/set_cc; S2 holds result/flags/set_cc; out_valid = S2 valid.
REQ-020 Latency: accept in cycle N -> out_valid in cycle N+2 when out_ready held high.
REQ-021 Handshake: transfer on valid & ready; in_ready = !flush & (!S1valid | S1 advances); S1 advances when !S2valid | out_ready.
REQ-022 Full throughput: one accept and one retire per cycle when out_ready held high.
REQ-023 Stall: out_ready low with S2 valid -> result, flags, out_valid held stable; S1 held; in_ready low if S1 valid.
REQ-024 Once asserted, out_valid stays high until the handshake completes (unless flush or reset).
REQ-025 cc updates to flags on the output handshake only if that beat's set_cc = 1; otherwise holds.
REQ-026 Flush: in_ready = 0 that cycle; an output handshake in the same cycle completes (cc updates per REQ-025); S1/S2 valids clear on the next edge.
REQ-027 Flush does not alter cc except via REQ-026.
REQ-028 No internal FIFO beyond the two stages; requests retire in order.

Reset
REQ-029 reset high: S1/S2 valids = 0, out_valid = 0, cc = CC_RESET, result = 0, flags = 0 on the next edge.
REQ-030 in_ready = 0 while reset is high; reset mid-operation drops all in-flight requests without a handshake.
REQ-031 reset has priority over flush and all handshakes.

Structure
REQ-032 Shared package alu_pkg: op encodings (OP_ADD, OP_SUB, OP_AND, OP_XOR), CC bit indices (CC_ZF=2, CC_SF=1, CC_OF=0), CC width constant.
REQ-033 Combinational sub-module alu_core (WIDTH-parametrised: op, a, b -> result, flags) instantiated between S1 and S2.

Verification
REQ-034 WIDTH=64, ADD a=0x7FFFFFFFFFFFFFFF, b=1, set_cc=1 -> result 0x8000000000000000, flags 3'b011, cc 3'b011 after handshake.
REQ-035 SUB a=5, b=5, set_cc=0 -> result 0, flags 3'b100, cc unchanged (CC_RESET).
REQ-036 Back-to-back XOR stream of 8 requests, out_ready=1 -> 8 results in order, first at cycle +2, one per cycle.
REQ-037 out_ready low 3 cycles with both stages full -> in_ready 0, result/flags stable, no loss/duplication after release.
REQ-038 flush with 2 in flight, out_ready=1 -> S2 beat retires that cycle, S1 request dropped, out_valid 0 next cycle.
REQ-039 WIDTH=8, AND a=0xF0, b=0x0F -> result 0x00, flags 3'b100; reset mid-stream -> out_valid 0, cc = CC_RESET.
